sram_ctrl: RTL

Multi-cycle memory controller between the MEM pipeline stage of the ARM core and an external single-port 32-bit SRAM. It accepts the MEM-stage read/write request (ALU result as byte address, Rm value as write data). It sequences the SRAM bus with a fixed number of wait states and produces `ready`, which the core inverts to drive pipeline `freeze` until the access completes. It replaces the zero-latency behavioural memory and is the first user of the IF/ID/EXE freeze path.

---
 rtl/sram_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//
// Multi-cycle controller between the core's MEM stage and an external
// single-port 32-bit SRAM. A load/store request seen in IDLE is latched,
// driven onto the SRAM bus for WAIT_CYCLES cycles (ACCESS), and acknowledged
// with a one-cycle ready pulse (DONE). The core derives freeze = ~o_ready.
//
// Optional feature macro: SRAM_WRITE_BUFFER_EN
//   defined   : stores are posted. ready=1 in the IDLE cycle the store is
//               seen, the store drains through ACCESS and returns straight
//               to IDLE without a DONE cycle.
//   undefined : stores stall exactly like loads.
//
// Parameters:
//   WAIT_CYCLES  SRAM bus cycles per access (1..15)
//   ADDR_W       SRAM word-address width
//   BASE_ADDR    byte address that maps to SRAM word 0
//
// Ports:
//   i_clk          clock, all state on the rising edge
//   i_rst          synchronous active-high reset
//   i_mem_r_en     load request
//   i_mem_w_en     store request (wins when both enables are high)
//   i_address      byte address (ALU result)
//   i_wr_data      store data
//   o_rd_data      registered load result
//   o_ready        access complete or no request pending
//   o_sram_addr    SRAM word address
//   o_sram_dq_out  SRAM write data
//   o_sram_dq_oe   SRAM data bus drive enable
//   i_sram_dq_in   SRAM read data
//   o_sram_we_n    SRAM write strobe, active low
//   o_sram_oe_n    SRAM output enable, active low
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sram_ctrl #(
   parameter int WAIT_CYCLES = 4,
   parameter int ADDR_W      = 16,
   parameter int BASE_ADDR   = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_mem_r_en,
   input  logic              i_mem_w_en,
   input  logic [31:0]       i_address,
   input  logic [31:0]       i_wr_data,
   output logic [31:0]       o_rd_data,
   output logic              o_ready,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [31:0]       o_sram_dq_out,
   output logic              o_sram_dq_oe,
   input  logic [31:0]       i_sram_dq_in,
   output logic              o_sram_we_n,
   output logic              o_sram_oe_n
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam int               CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_is_write;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rd_data;

   logic              w_req;
   logic              w_start;
   logic [31:0]       w_offset;
   logic [ADDR_W-1:0] w_word;

   assign w_req    = i_mem_r_en | i_mem_w_en;
   assign w_start  = (r_state == S_IDLE) && w_req;
   // Addresses below BASE_ADDR wrap through the subtraction; byte lane bits
   // are dropped by the shift, upper bits by the truncation.
   assign w_offset = i_address - 32'(BASE_ADDR);
   assign w_word   = ADDR_W'(w_offset >> 2);

   // ---------------------------------------------------------------- state reg
   // NOTE: flops are written with non-blocking assignments so every register
   // samples the values present before the clock edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------ request / datapath
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_is_write <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rd_data  <= '0;
      end else if (w_start) begin
         // Store has priority when both enables are set.
         r_is_write <= i_mem_w_en;
         r_addr     <= w_word;
         r_wdata    <= i_wr_data;
         r_cnt      <= CNT_LOAD;
      end else if (r_state == S_ACCESS) begin
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end else if (!r_is_write) begin
            // Last bus cycle of a load: data is stable, capture it.
            r_rd_data <= i_sram_dq_in;
         end
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      // NOTE: the default assignment up front means every path assigns
      // w_next, so no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req) w_next = S_ACCESS;
         end
         S_ACCESS: begin
            if (r_cnt == '0) begin
`ifdef SRAM_WRITE_BUFFER_EN
               // Posted stores were acknowledged up front; no DONE cycle.
               w_next = r_is_write ? S_IDLE : S_DONE;
`else
               w_next = S_DONE;
`endif
            end
         end
         // The request still visible in DONE is the one just serviced.
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      o_ready      = 1'b0;
      o_sram_we_n  = 1'b1;
      o_sram_oe_n  = 1'b1;
      o_sram_dq_oe = 1'b0;
      case (r_state)
         S_IDLE: begin
`ifdef SRAM_WRITE_BUFFER_EN
            o_ready = !w_req || i_mem_w_en;
`else
            o_ready = !w_req;
`endif
         end
         S_ACCESS: begin
            o_sram_we_n  = !r_is_write;
            o_sram_oe_n  = r_is_write;
            o_sram_dq_oe = r_is_write;
         end
         S_DONE:  o_ready = 1'b1;
         default: o_ready = 1'b0;
      endcase
   end

   assign o_sram_addr   = r_addr;
   assign o_sram_dq_out = r_wdata;
   assign o_rd_data     = r_rd_data;

endmodule
